// File: rtl/rx_frame_checker.sv
// rx_frame_checker: strips length header and checksum word from the RX MAC word
//   stream, verifies the ones-complement checksum, issues payload with sof/eof.
// Latency: payload word k leaves one cycle after the next input word is sampled
//   (word k+1 or the checksum), so the last word carries the verdict.
// Backpressure: none; downstream accepts one word every cycle.
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_sof/in_eof/in_data           : MAC word stream
//   validtodatastorage/datatoRAMsof/eof/datatoRAM : payload to storage
//   length        : payload bytes rounded up to even, stable sof..eof
//   checksummatch : frame verdict, meaningful while datatoRAMeof=1
//   frames_ok/frames_bad : saturating frame statistics
module rx_frame_checker #(
  parameter int MAX_LEN = 1500,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [15:0]      in_data,
  output logic             validtodatastorage,
  output logic             datatoRAMsof,
  output logic             datatoRAMeof,
  output logic [15:0]      datatoRAM,
  output logic [15:0]      length,
  output logic             checksummatch,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DROP} state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [15:0] hold_dat, hold_dat_nxt;
  logic        hold_vld, hold_vld_nxt;
  logic        first_pend, first_pend_nxt;   // next emitted word is the frame's first
  logic [15:0] sum, sum_nxt;
  logic [15:0] words_left, words_left_nxt;
  logic [15:0] length_nxt;

  logic        out_vld_nxt, out_sof_nxt, out_eof_nxt, out_match_nxt;
  logic [15:0] out_dat_nxt;
  logic        ok_inc;
  logic [1:0]  bad_inc;     // a terminated frame plus a rejected header can both count
  logic        take_hdr;

  logic [CNT_W-1:0] frames_ok_nxt, frames_bad_nxt;

  // Header decode: word count N = ceil(L/2), even length = 2*N.
  logic [16:0] hdr_round;
  logic [15:0] hdr_words;
  logic        hdr_bad;

  assign hdr_round = {1'b0, in_data} + 17'd1;
  assign hdr_words = hdr_round[16:1];
  assign hdr_bad   = (in_data == 16'd0) || (in_data > MAX_LEN_W);

  // 16-bit ones-complement add; the re-added carry can never carry again.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  always_comb begin
    state_nxt      = state;
    hold_dat_nxt   = hold_dat;
    hold_vld_nxt   = hold_vld;
    first_pend_nxt = first_pend;
    sum_nxt        = sum;
    words_left_nxt = words_left;
    length_nxt     = length;
    out_vld_nxt    = 1'b0;
    out_sof_nxt    = 1'b0;
    out_eof_nxt    = 1'b0;
    out_match_nxt  = 1'b0;
    out_dat_nxt    = datatoRAM;
    ok_inc         = 1'b0;
    bad_inc        = 2'd0;
    take_hdr       = 1'b0;

    if (in_valid) begin
      case (state)
        IDLE: take_hdr = in_sof;

        DROP: begin
          if (in_sof)      take_hdr  = 1'b1;
          else if (in_eof) state_nxt = IDLE;
        end

        PAYLOAD: begin
          if (in_sof || in_eof) begin
            // Frame cut short: flush the held word as a failed eof.
            if (hold_vld) begin
              out_vld_nxt    = 1'b1;
              out_sof_nxt    = first_pend;
              out_eof_nxt    = 1'b1;
              out_dat_nxt    = hold_dat;
              first_pend_nxt = 1'b0;
            end
            hold_vld_nxt = 1'b0;
            bad_inc      = 2'd1;
            state_nxt    = IDLE;
            take_hdr     = in_sof;
          end else begin
            if (hold_vld) begin
              out_vld_nxt    = 1'b1;
              out_sof_nxt    = first_pend;
              out_dat_nxt    = hold_dat;
              first_pend_nxt = 1'b0;
            end
            hold_dat_nxt   = in_data;
            hold_vld_nxt   = 1'b1;
            sum_nxt        = oc_add(sum, in_data);
            words_left_nxt = words_left - 16'd1;
            if (words_left == 16'd1) state_nxt = CHECK;
          end
        end

        CHECK: begin
          // The held word is always valid here since N >= 1.
          out_vld_nxt    = 1'b1;
          out_sof_nxt    = first_pend;
          out_eof_nxt    = 1'b1;
          out_dat_nxt    = hold_dat;
          first_pend_nxt = 1'b0;
          hold_vld_nxt   = 1'b0;
          if (in_sof) begin
            bad_inc   = 2'd1;
            state_nxt = IDLE;
            take_hdr  = 1'b1;
          end else begin
            out_match_nxt = (sum == ~in_data) && in_eof;
            if ((sum == ~in_data) && in_eof) ok_inc  = 1'b1;
            else                             bad_inc = 2'd1;
            state_nxt = in_eof ? IDLE : DROP;
          end
        end

        default: state_nxt = IDLE;
      endcase

      if (take_hdr) begin
        hold_vld_nxt = 1'b0;
        if (hdr_bad || in_eof) begin
          bad_inc   = bad_inc + 2'd1;
          state_nxt = in_eof ? IDLE : DROP;
        end else begin
          state_nxt      = PAYLOAD;
          length_nxt     = {hdr_words[14:0], 1'b0};
          words_left_nxt = hdr_words;
          sum_nxt        = in_data;
          first_pend_nxt = 1'b1;
        end
      end
    end
  end

  // Saturating statistics counters.
  logic [CNT_W+1:0] ok_wide, bad_wide;
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  always_comb begin
    ok_wide        = {2'b00, frames_ok}  + {{(CNT_W+1){1'b0}}, ok_inc};
    bad_wide       = {2'b00, frames_bad} + {{CNT_W{1'b0}}, bad_inc};
    frames_ok_nxt  = (ok_wide  > CNT_MAX) ? {CNT_W{1'b1}} : ok_wide[CNT_W-1:0];
    frames_bad_nxt = (bad_wide > CNT_MAX) ? {CNT_W{1'b1}} : bad_wide[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      hold_dat           <= '0;
      hold_vld           <= 1'b0;
      first_pend         <= 1'b0;
      sum                <= '0;
      words_left         <= '0;
      length             <= '0;
      validtodatastorage <= 1'b0;
      datatoRAMsof       <= 1'b0;
      datatoRAMeof       <= 1'b0;
      datatoRAM          <= '0;
      checksummatch      <= 1'b0;
      frames_ok          <= '0;
      frames_bad         <= '0;
    end else begin
      state              <= state_nxt;
      hold_dat           <= hold_dat_nxt;
      hold_vld           <= hold_vld_nxt;
      first_pend         <= first_pend_nxt;
      sum                <= sum_nxt;
      words_left         <= words_left_nxt;
      length             <= length_nxt;
      validtodatastorage <= out_vld_nxt;
      datatoRAMsof       <= out_sof_nxt;
      datatoRAMeof       <= out_eof_nxt;
      datatoRAM          <= out_dat_nxt;
      checksummatch      <= out_match_nxt;
      frames_ok          <= frames_ok_nxt;
      frames_bad         <= frames_bad_nxt;
    end
  end

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: directed frames with hand-computed outputs for rx_frame_checker.
// Inputs change mid-cycle; outputs are checked 1 time unit after each rising edge.
// Covers good/odd/bad-checksum frames, gaps, oversize header, truncation, sof restart, reset.
module tb_rx_frame_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [15:0] in_data = '0;
  logic        validtodatastorage, datatoRAMsof, datatoRAMeof, checksummatch;
  logic [15:0] datatoRAM, length;
  logic [15:0] frames_ok, frames_bad;

  int n_cmp = 0;
  int n_bad = 0;

  rx_frame_checker #(.MAX_LEN(1500), .CNT_W(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_sof             (in_sof),
    .in_eof             (in_eof),
    .in_data            (in_data),
    .validtodatastorage (validtodatastorage),
    .datatoRAMsof       (datatoRAMsof),
    .datatoRAMeof       (datatoRAMeof),
    .datatoRAM          (datatoRAM),
    .length             (length),
    .checksummatch      (checksummatch),
    .frames_ok          (frames_ok),
    .frames_bad         (frames_bad)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one input cycle, then sample just after the capturing edge.
  task automatic step(input logic v, input logic s, input logic e, input logic [15:0] d);
    @(negedge clock);
    in_valid = v;
    in_sof   = s;
    in_eof   = e;
    in_data  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic expect_none(input string tag);
    check({tag, ".vld"}, 32'(validtodatastorage), 32'd0);
  endtask

  task automatic expect_word(input string tag, input logic s, input logic e,
                             input logic [15:0] d, input logic m);
    check({tag, ".vld"}, 32'(validtodatastorage), 32'd1);
    check({tag, ".sof"}, 32'(datatoRAMsof), 32'(s));
    check({tag, ".eof"}, 32'(datatoRAMeof), 32'(e));
    check({tag, ".dat"}, 32'(datatoRAM), 32'(d));
    if (e) check({tag, ".match"}, 32'(checksummatch), 32'(m));
  endtask

  // Header 4, payload 0x1234 0x5678, checksum word c.
  task automatic frame4(input string tag, input logic [15:0] c, input logic m);
    step(1, 1, 0, 16'h0004); expect_none({tag, ".hdr"});
    step(1, 0, 0, 16'h1234); expect_none({tag, ".w0"});
    check({tag, ".len"}, 32'(length), 32'd4);
    step(1, 0, 0, 16'h5678); expect_word({tag, ".o0"}, 1, 0, 16'h1234, 0);
    step(1, 0, 1, c);        expect_word({tag, ".o1"}, 0, 1, 16'h5678, m);
    step(0, 0, 0, 16'h0000); expect_none({tag, ".after"});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst.vld",   32'(validtodatastorage), 32'd0);
    check("rst.sof",   32'(datatoRAMsof), 32'd0);
    check("rst.eof",   32'(datatoRAMeof), 32'd0);
    check("rst.dat",   32'(datatoRAM), 32'd0);
    check("rst.len",   32'(length), 32'd0);
    check("rst.match", 32'(checksummatch), 32'd0);
    check("rst.ok",    32'(frames_ok), 32'd0);
    check("rst.bad",   32'(frames_bad), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Good frame: 4+0x1234+0x5678 = 0x68B0 = ~0x974F
    frame4("good", 16'h974F, 1);
    check("good.ok",  32'(frames_ok), 32'd1);
    check("good.bad", 32'(frames_bad), 32'd0);

    // Odd length: 3+0xABCD+0xEF00 = 0x19AD0 -> 0x9AD1 = ~0x652E
    step(1, 1, 0, 16'h0003); expect_none("odd.hdr");
    step(1, 0, 0, 16'hABCD); expect_none("odd.w0");
    check("odd.len", 32'(length), 32'd4);
    step(1, 0, 0, 16'hEF00); expect_word("odd.o0", 1, 0, 16'hABCD, 0);
    step(1, 0, 1, 16'h652E); expect_word("odd.o1", 0, 1, 16'hEF00, 1);
    check("odd.ok", 32'(frames_ok), 32'd2);

    // Bad checksum
    frame4("badc", 16'h974E, 0);
    check("badc.ok",  32'(frames_ok), 32'd2);
    check("badc.bad", 32'(frames_bad), 32'd1);

    // Gaps plus a single payload word: 2+0xBEEF = 0xBEF1 = ~0x410E
    step(1, 1, 0, 16'h0002); expect_none("gap.hdr");
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 16'h0000); expect_none("gap.idle1"); end
    step(1, 0, 0, 16'hBEEF); expect_none("gap.w0");
    check("gap.len", 32'(length), 32'd2);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 16'h0000); expect_none("gap.idle2"); end
    step(1, 0, 1, 16'h410E); expect_word("gap.o0", 1, 1, 16'hBEEF, 1);
    step(0, 0, 0, 16'h0000); expect_none("gap.after");
    check("gap.ok", 32'(frames_ok), 32'd3);

    // Oversize header: dropped until eof, no outputs
    step(1, 1, 0, 16'h0600); expect_none("big.hdr");
    check("big.bad", 32'(frames_bad), 32'd2);
    step(1, 0, 0, 16'h1111); expect_none("big.w0");
    step(1, 0, 0, 16'h2222); expect_none("big.w1");
    step(1, 0, 1, 16'h3333); expect_none("big.eof");
    check("big.bad2", 32'(frames_bad), 32'd2);

    // Premature eof: header 6, eof on the 2nd payload word
    step(1, 1, 0, 16'h0006); expect_none("trunc.hdr");
    step(1, 0, 0, 16'hAAAA); expect_none("trunc.w0");
    step(1, 0, 1, 16'hBBBB); expect_word("trunc.o0", 1, 1, 16'hAAAA, 0);
    check("trunc.bad", 32'(frames_bad), 32'd3);
    check("trunc.ok",  32'(frames_ok), 32'd3);

    // sof mid-payload terminates the frame, same word starts a good frame
    step(1, 1, 0, 16'h0006); expect_none("sofr.hdr");
    step(1, 0, 0, 16'h1111); expect_none("sofr.w0");
    step(1, 0, 0, 16'h2222); expect_word("sofr.o0", 1, 0, 16'h1111, 0);
    step(1, 1, 0, 16'h0004); expect_word("sofr.o1", 0, 1, 16'h2222, 0);
    check("sofr.bad", 32'(frames_bad), 32'd4);
    step(1, 0, 0, 16'h1234); expect_none("sofr.w2");
    check("sofr.len", 32'(length), 32'd4);
    step(1, 0, 0, 16'h5678); expect_word("sofr.o2", 1, 0, 16'h1234, 0);
    step(1, 0, 1, 16'h974F); expect_word("sofr.o3", 0, 1, 16'h5678, 1);
    check("sofr.ok", 32'(frames_ok), 32'd4);

    // Reset mid-frame, while an output word is being presented
    step(1, 1, 0, 16'h0006); expect_none("mrst.hdr");
    step(1, 0, 0, 16'h1111); expect_none("mrst.w0");
    step(1, 0, 0, 16'h2222); expect_word("mrst.o0", 1, 0, 16'h1111, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mrst.vld", 32'(validtodatastorage), 32'd0);
    check("mrst.sof", 32'(datatoRAMsof), 32'd0);
    check("mrst.dat", 32'(datatoRAM), 32'd0);
    check("mrst.len", 32'(length), 32'd0);
    check("mrst.ok",  32'(frames_ok), 32'd0);
    check("mrst.bad", 32'(frames_bad), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    frame4("post", 16'h974F, 1);
    check("post.ok",  32'(frames_ok), 32'd1);
    check("post.bad", 32'(frames_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
- Receive-side stage directly upstream of the RX data storage block.
- Parses the 16-bit word stream coming from the receive MAC, strips the length header and trailing checksum word, and verifies the checksum.
- Presents payload words with sof/eof, a word-aligned length, and a checksum verdict on the eof cycle. Storage uses that verdict to commit or roll back the frame.
- No backpressure: the downstream stage accepts one word every cycle.

Parameters:
MAX_LEN, 1500, largest legal payload length in bytes; larger headers drop the frame.
CNT_W, 16, width of the saturating frame statistics counters.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  input word qualifier.
in_sof  in  1  first word of frame (header); qualified by in_valid.
in_eof  in  1  last word of frame; qualified by in_valid.
in_data  in  16  input word.
validtodatastorage  out  1  payload word valid.
datatoRAMsof  out  1  first payload word of frame.
datatoRAMeof  out  1  last payload word of frame.
datatoRAM  out  16  payload word.
length  out  16  payload length, bytes rounded up to even; stable from sof through eof.
checksummatch  out  1  frame good; meaningful only while datatoRAMeof=1.
frames_ok  out  CNT_W  saturating count of frames ending with checksummatch=1.
frames_bad  out  CNT_W  saturating count of dropped or failed frames.

Behaviour:
- Frame format on input:
  - Word 0: header = payload length L in bytes.
  - Then N = ceil(L/2) payload words; an odd L leaves the last low byte as padding.
  - Then one checksum word C.
- Checksum rule:
  - S = 16-bit ones-complement sum (end-around carry) of the header and all payload words.
  - Match requires S == ~C and in_eof=1 on the C word.
- Reset: every output, all state and both counters are 0; FSM returns to IDLE. A frame in flight at reset is discarded with no eof emitted.
- All outputs are registered.
- One-word hold register delays payload, so the last payload word can be issued together with the verdict:
  - Payload word k is emitted in the cycle after the input word following it is sampled. That following word is word k+1 or C.
  - Latency therefore follows the input gaps; output valid is a single-cycle pulse per word.
- FSM states:
  - IDLE:
    - Wait for in_valid & in_sof.
    - Latch header: if L==0 or L>MAX_LEN, go to DROP and increment frames_bad.
    - Otherwise set length = 2*N, words_left = N, S = header, and go to PAYLOAD.
    - If in_eof is also set on the header word, increment frames_bad and stay in IDLE.
  - PAYLOAD:
    - Each valid word goes into the hold register and is added to S; words_left decrements.
    - The previously held word, if any, is emitted; the first emitted word carries datatoRAMsof=1.
    - When words_left reaches 0, go to CHECK.
  - CHECK:
    - The next valid word is C.
    - Emit the held word with datatoRAMeof=1 and checksummatch=(S==~C)&in_eof.
    - If the match is 1, increment frames_ok; otherwise increment frames_bad.
    - Go to IDLE if in_eof, else go to DROP.
  - DROP: ignore words until in_valid & in_eof, then go to IDLE. No outputs are produced.
- N==1: the single word is emitted in CHECK with datatoRAMsof=1 and datatoRAMeof=1 in the same cycle.
- Premature in_eof in PAYLOAD:
  - If a word is already held, emit it with datatoRAMeof=1 and checksummatch=0, then go to IDLE.
  - The arriving word is discarded.
  - frames_bad increments in either case, whether or not a word was held.
- in_sof while in PAYLOAD or CHECK:
  - Terminate the current frame as for a premature in_eof, with eof and checksummatch=0 if a word is held.
  - The same word is then processed as a new header, per the IDLE rules.
- in_sof in DROP: treated as a new header, per the IDLE rules.
- in_valid=0: no state change and no output.
- Counters saturate at all-ones.

Test Plan:
- Good frame: header 0x0004, payload 0x1234, 0x5678, C=0x974F with in_eof -> words 0x1234 (sof), 0x5678 (eof, checksummatch=1); length=4; frames_ok=1.
- Odd length: header 0x0003, payload 0xABCD, 0xEF00, C=0x652E with eof -> length=4, two words out, checksummatch=1 (S=0x9AD1 after end-around carry).
- Bad checksum: repeat the first case with C=0x974E -> same words out, eof with checksummatch=0; frames_bad=1.
- Gaps plus single word: header 0x0002, payload 0xBEEF, C=~(0x0002+0xBEEF)=0x410E, in_valid low 3 cycles between words -> exactly one output pulse with sof=eof=1 and match=1, in the cycle after C is sampled.
- Errors:
  - Header 0x0600 (>MAX_LEN) -> no outputs until in_eof; frames_bad increments.
  - Header 0x0006 with in_eof on the 2nd payload word -> 1st payload word emitted with eof and match=0.
- Reset mid-frame: drive reset low after 2 payload words -> all outputs 0 immediately. A following good frame passes normally.
